tx_resp_arbiter: RTL and testbench

- Shares the single UART transmit path between two response sources in the REF_CLK domain: register-file read data (1 byte) and ALU results (2 bytes).
- Captures each response into a one-deep holding slot and arbitrates round-robin between the slots.
- Serialises the 16-bit ALU result as LSB then MSB, and paces every byte on the synchronised TX busy handshake.
- Sits between the system controller's response outputs and the TX data synchroniser.

---
 rtl/tx_resp_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_tx_resp_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter that shares one UART TX byte path between a 1-byte
// register-file response slot and a 2-byte ALU response slot (LSB first).
module tx_resp_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RF_DATA,
   input  logic                      RF_VLD,
   input  logic [2*DATA_WIDTH-1:0]   ALU_DATA,
   input  logic                      ALU_VLD,
   input  logic                      BUSY,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD,
   output logic                      RF_PEND,
   output logic                      ALU_PEND,
   output logic                      OVERRUN,
   output logic                      TO_ERR
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic                      rf_pend_reg, rf_pend_next;
   logic [DATA_WIDTH-1:0]     rf_data_reg, rf_data_next;
   logic                      alu_pend_reg, alu_pend_next;
   logic [2*DATA_WIDTH-1:0]   alu_data_reg, alu_data_next;
   // MSB is copied out of the ALU slot at grant so the slot can refill meanwhile
   logic [DATA_WIDTH-1:0]     msb_reg, msb_next;
   logic                      msb_owed_reg, msb_owed_next;
   logic                      rf_first_reg, rf_first_next;
   logic [DATA_WIDTH-1:0]     tx_data_reg, tx_data_next;
   logic                      tx_vld_reg, tx_vld_next;
   logic                      overrun_reg, overrun_next;
   logic                      to_err_reg, to_err_next;
   logic                      grant_rf, grant_alu;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         rf_pend_reg  <= 1'b0;
         rf_data_reg  <= '0;
         alu_pend_reg <= 1'b0;
         alu_data_reg <= '0;
         msb_reg      <= '0;
         msb_owed_reg <= 1'b0;
         rf_first_reg <= 1'b1;
         tx_data_reg  <= '0;
         tx_vld_reg   <= 1'b0;
         overrun_reg  <= 1'b0;
         to_err_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         rf_pend_reg  <= rf_pend_next;
         rf_data_reg  <= rf_data_next;
         alu_pend_reg <= alu_pend_next;
         alu_data_reg <= alu_data_next;
         msb_reg      <= msb_next;
         msb_owed_reg <= msb_owed_next;
         rf_first_reg <= rf_first_next;
         tx_data_reg  <= tx_data_next;
         tx_vld_reg   <= tx_vld_next;
         overrun_reg  <= overrun_next;
         to_err_reg   <= to_err_next;
      end
   end

   // Grant decision: only in IDLE with the transmitter free
   always_comb begin
      grant_rf  = 1'b0;
      grant_alu = 1'b0;
      if (state_reg == IDLE && !BUSY) begin
         if (rf_pend_reg && alu_pend_reg) begin
            grant_rf  = rf_first_reg;
            grant_alu = !rf_first_reg;
         end else begin
            grant_rf  = rf_pend_reg;
            grant_alu = alu_pend_reg;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      rf_pend_next  = rf_pend_reg;
      rf_data_next  = rf_data_reg;
      alu_pend_next = alu_pend_reg;
      alu_data_next = alu_data_reg;
      msb_next      = msb_reg;
      msb_owed_next = msb_owed_reg;
      rf_first_next = rf_first_reg;
      tx_data_next  = tx_data_reg;
      tx_vld_next   = tx_vld_reg;
      overrun_next  = overrun_reg;
      to_err_next   = to_err_reg;

      // A slot being granted this cycle is free to accept a new response
      if (grant_rf)
         rf_pend_next = 1'b0;
      if (RF_VLD) begin
         if (!rf_pend_reg || grant_rf) begin
            rf_data_next = RF_DATA;
            rf_pend_next = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end

      if (grant_alu)
         alu_pend_next = 1'b0;
      if (ALU_VLD) begin
         if (!alu_pend_reg || grant_alu) begin
            alu_data_next = ALU_DATA;
            alu_pend_next = 1'b1;
         end else begin
            overrun_next = 1'b1;
         end
      end

      case (state_reg)
         IDLE: begin
            if (grant_rf) begin
               tx_data_next  = rf_data_reg;
               tx_vld_next   = 1'b1;
               cnt_next      = '0;
               msb_owed_next = 1'b0;
               rf_first_next = 1'b0;
               state_next    = SEND;
            end else if (grant_alu) begin
               tx_data_next  = alu_data_reg[DATA_WIDTH-1:0];
               msb_next      = alu_data_reg[2*DATA_WIDTH-1:DATA_WIDTH];
               msb_owed_next = 1'b1;
               tx_vld_next   = 1'b1;
               cnt_next      = '0;
               rf_first_next = 1'b1;
               state_next    = SEND;
            end
         end
         SEND: begin
            if (BUSY) begin
               tx_vld_next = 1'b0;
               state_next  = WAIT_LO;
            end else if (cnt_reg == CNT_LAST) begin
               // Receiver never answered: abandon the rest of this response
               tx_vld_next   = 1'b0;
               to_err_next   = 1'b1;
               msb_owed_next = 1'b0;
               state_next    = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         WAIT_LO: begin
            if (!BUSY) begin
               if (msb_owed_reg) begin
                  tx_data_next  = msb_reg;
                  tx_vld_next   = 1'b1;
                  cnt_next      = '0;
                  msb_owed_next = 1'b0;
                  state_next    = SEND;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next  = IDLE;
            tx_vld_next = 1'b0;
         end
      endcase
   end

   assign TX_P_DATA = tx_data_reg;
   assign TX_D_VLD  = tx_vld_reg;
   assign RF_PEND   = rf_pend_reg;
   assign ALU_PEND  = alu_pend_reg;
   assign OVERRUN   = overrun_reg;
   assign TO_ERR    = to_err_reg;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed bench for tx_resp_arbiter: cycle-exact vector table followed by
// hand-written sequences for ordering, overrun, timeout and mid-frame reset.
module tb_tx_resp_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rf_data = '0;
   logic        rf_vld = 1'b0;
   logic [15:0] alu_data = '0;
   logic        alu_vld = 1'b0;
   logic        busy = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_vld;
   logic        rf_pend;
   logic        alu_pend;
   logic        overrun;
   logic        to_err;

   int checks = 0;
   int errors = 0;

   tx_resp_arbiter #(.DATA_WIDTH(8), .TIMEOUT(8)) dut (
      .CLK       (clk),
      .RST       (rst),
      .RF_DATA   (rf_data),
      .RF_VLD    (rf_vld),
      .ALU_DATA  (alu_data),
      .ALU_VLD   (alu_vld),
      .BUSY      (busy),
      .TX_P_DATA (tx_data),
      .TX_D_VLD  (tx_vld),
      .RF_PEND   (rf_pend),
      .ALU_PEND  (alu_pend),
      .OVERRUN   (overrun),
      .TO_ERR    (to_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rf_vld;
      logic [7:0]  rf_data;
      logic        alu_vld;
      logic [15:0] alu_data;
      logic        busy;
      logic [7:0]  e_data;
      logic        e_vld;
      logic        e_rfp;
      logic        e_alup;
      logic        e_ovr;
      logic        e_to;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(logic r, logic rv, logic [7:0] rd, logic av,
                                logic [15:0] ad, logic b, logic [7:0] ed,
                                logic ev, logic erp, logic eap, logic eo, logic et);
      vec_t v;
      v.rst = r;  v.rf_vld = rv; v.rf_data = rd; v.alu_vld = av; v.alu_data = ad;
      v.busy = b; v.e_data = ed; v.e_vld = ev; v.e_rfp = erp; v.e_alup = eap;
      v.e_ovr = eo; v.e_to = et;
      return v;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_vld(input string nm, input logic [7:0] exp);
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
         step;
         if (tx_vld) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s: got no TX_D_VLD within 20 cycles expected byte %02h", nm, exp);
      end else begin
         $display("tx byte %02h (%s)", tx_data, nm);
         chk(nm, tx_data, exp);
      end
   endtask

   task automatic handshake(input string nm);
      busy = 1'b1;
      step;
      chk({nm, " vld drop"}, tx_vld, 1'b0);
      step;
      busy = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      step;
      rst = 1'b0;
   endtask

   initial begin
      bit hit;
      int n;

      // Reset, then RF 0xA5 and ALU 0x1234 with exact cycle timing
      vecs.push_back(mkv(1, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 1, 8'hA5, 0, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'hA5, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'hA5, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'hA5, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 1, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 1, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 1, 16'h1234, 0, 8'hA5, 0, 0, 1, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'h34, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 1, 8'h34, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 1, 8'h34, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'h12, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'h12, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 1, 8'h12, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'h12, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(0, 0, 8'h00, 0, 16'h0000, 0, 8'h12, 0, 0, 0, 0, 0));

      step;
      foreach (vecs[i]) begin
         rst      = vecs[i].rst;
         rf_vld   = vecs[i].rf_vld;
         rf_data  = vecs[i].rf_data;
         alu_vld  = vecs[i].alu_vld;
         alu_data = vecs[i].alu_data;
         busy     = vecs[i].busy;
         step;
         $display("vec %0d: data %02h vld %0b rfp %0b alup %0b ovr %0b to %0b",
                  i, tx_data, tx_vld, rf_pend, alu_pend, overrun, to_err);
         chk($sformatf("vec%0d data", i), tx_data, vecs[i].e_data);
         chk($sformatf("vec%0d vld", i), tx_vld, vecs[i].e_vld);
         chk($sformatf("vec%0d rf_pend", i), rf_pend, vecs[i].e_rfp);
         chk($sformatf("vec%0d alu_pend", i), alu_pend, vecs[i].e_alup);
         chk($sformatf("vec%0d overrun", i), overrun, vecs[i].e_ovr);
         chk($sformatf("vec%0d to_err", i), to_err, vecs[i].e_to);
      end
      rst = 1'b0; rf_vld = 1'b0; alu_vld = 1'b0; busy = 1'b0;

      // Simultaneous responses after reset: RF first, then ALU LSB/MSB
      do_reset;
      rf_vld = 1'b1; rf_data = 8'h5A; alu_vld = 1'b1; alu_data = 16'hBEEF;
      step;
      rf_vld = 1'b0; alu_vld = 1'b0;
      chk("both rf_pend", rf_pend, 1'b1);
      chk("both alu_pend", alu_pend, 1'b1);
      wait_vld("pair1 b0", 8'h5A); handshake("pair1 b0");
      wait_vld("pair1 b1", 8'hEF); handshake("pair1 b1");
      wait_vld("pair1 b2", 8'hBE); handshake("pair1 b2");
      // RF-only response so RF is the last grant before the next pair
      rf_vld = 1'b1; rf_data = 8'h77;
      step;
      rf_vld = 1'b0;
      wait_vld("rf only", 8'h77); handshake("rf only");
      rf_vld = 1'b1; rf_data = 8'h5A; alu_vld = 1'b1; alu_data = 16'hBEEF;
      step;
      rf_vld = 1'b0; alu_vld = 1'b0;
      wait_vld("pair2 b0", 8'hEF); handshake("pair2 b0");
      wait_vld("pair2 b1", 8'hBE); handshake("pair2 b1");
      wait_vld("pair2 b2", 8'h5A); handshake("pair2 b2");

      // RF_VLD on the RF grant edge is accepted without overrun
      do_reset;
      rf_vld = 1'b1; rf_data = 8'h44;
      step;
      rf_data = 8'h55;
      step;
      rf_vld = 1'b0;
      chk("grant-edge data", tx_data, 8'h44);
      chk("grant-edge vld", tx_vld, 1'b1);
      chk("grant-edge rf_pend", rf_pend, 1'b1);
      chk("grant-edge overrun", overrun, 1'b0);
      handshake("grant-edge b0");
      wait_vld("grant-edge b1", 8'h55); handshake("grant-edge b1");
      chk("grant-edge overrun after", overrun, 1'b0);

      // Overrun while in WAIT_LO; held RF byte survives and MSB is not preempted
      alu_vld = 1'b1; alu_data = 16'h3388;
      step;
      alu_vld = 1'b0;
      wait_vld("ovr lsb", 8'h88);
      busy = 1'b1;
      step;
      chk("ovr lsb drop", tx_vld, 1'b0);
      rf_vld = 1'b1; rf_data = 8'h11;
      step;
      chk("ovr first capture", overrun, 1'b0);
      chk("ovr rf_pend", rf_pend, 1'b1);
      rf_data = 8'h22;
      step;
      rf_vld = 1'b0;
      chk("ovr set", overrun, 1'b1);
      busy = 1'b0;
      wait_vld("ovr msb", 8'h33); handshake("ovr msb");
      wait_vld("ovr kept", 8'h11); handshake("ovr kept");
      chk("ovr sticky", overrun, 1'b1);

      // Timeout with BUSY stuck low: LSB held exactly 8 cycles, MSB dropped
      do_reset;
      busy = 1'b0;
      alu_vld = 1'b1; alu_data = 16'hCAFE;
      step;
      alu_vld = 1'b0;
      step;
      chk("to grant vld", tx_vld, 1'b1);
      chk("to grant data", tx_data, 8'hFE);
      n = 1;
      for (int i = 0; i < 30; i++) begin
         step;
         if (tx_vld) n++;
         else break;
      end
      $display("timeout: TX_D_VLD high %0d cycles", n);
      chk("to vld cycles", n, 8);
      chk("to_err set", to_err, 1'b1);
      hit = 0;
      for (int i = 0; i < 12; i++) begin
         step;
         if (tx_vld) hit = 1;
      end
      chk("to msb never sent", hit, 1'b0);
      chk("to data held", tx_data, 8'hFE);
      rf_vld = 1'b1; rf_data = 8'h66;
      step;
      rf_vld = 1'b0;
      wait_vld("after timeout", 8'h66); handshake("after timeout");

      // Reset in SEND mid-ALU response with an RF byte also pending
      alu_vld = 1'b1; alu_data = 16'hABCD;
      step;
      alu_vld = 1'b0;
      wait_vld("rst lsb", 8'hCD);
      rf_vld = 1'b1; rf_data = 8'h99;
      step;
      rf_vld = 1'b0;
      chk("rst pre rf_pend", rf_pend, 1'b1);
      chk("rst pre to_err", to_err, 1'b1);
      rst = 1'b1;
      step;
      chk("rst data", tx_data, 8'h00);
      chk("rst vld", tx_vld, 1'b0);
      chk("rst rf_pend", rf_pend, 1'b0);
      chk("rst alu_pend", alu_pend, 1'b0);
      chk("rst overrun", overrun, 1'b0);
      chk("rst to_err", to_err, 1'b0);
      rst = 1'b0;
      hit = 0;
      for (int i = 0; i < 15; i++) begin
         busy = (i == 3 || i == 4);
         step;
         if (tx_vld) hit = 1;
      end
      busy = 1'b0;
      chk("rst nothing sent", hit, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
